// File: rtl/gnn_frame_loader.sv
// gnn_frame_loader: serial frame loader feeding the 4-node GNN array.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_valid/s_ready       stream handshake; s_ready = ~shadow_full
//   s_data, s_last        signed stream word, end-of-frame marker
//   node_ready            {out10_ready_node3..node0} from the array
//   feat, wgt             committed frame (16 features, 24 weights)
//   in_ready              frame valid to the array
//   frame_err             1-cycle pulse: malformed frame dropped
//   timeout               1-cycle pulse: RUN watchdog fired
//   frame_cnt             completed frames, wraps 255->0
// Optional feature: define GNN_LOADER_TIMEOUT_EN to enable the RUN watchdog.
module gnn_frame_loader #(
  parameter int DATA_W      = 5,
  parameter int N_WORDS     = 40,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  input  logic                 s_last,
  input  logic [3:0]           node_ready,
  output logic [16*DATA_W-1:0] feat,
  output logic [24*DATA_W-1:0] wgt,
  output logic                 in_ready,
  output logic                 frame_err,
  output logic                 timeout,
  output logic [7:0]           frame_cnt
);
  localparam int N_FEAT = 16;
  localparam int N_WGT  = 24;
  typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;
  state_t                 state_q;
  logic [DATA_W-1:0]      shadow_q [N_WORDS];
  logic [5:0]             wr_idx_q, wr_idx_d;
  logic                   shadow_full_q, shadow_full_d;
  logic                   frame_err_q, frame_err_d;
  logic [16*DATA_W-1:0]   feat_q;
  logic [24*DATA_W-1:0]   wgt_q;
  logic                   in_ready_q;
  logic [7:0]             frame_cnt_q;
  logic                   wr_en, at_end, commit;
`ifdef GNN_LOADER_TIMEOUT_EN
  logic [15:0]            tmo_cnt_q;
  logic                   timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif
  assign s_ready   = ~shadow_full_q;
  assign feat      = feat_q;
  assign wgt       = wgt_q;
  assign in_ready  = in_ready_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;
  assign wr_en     = s_valid & s_ready;
  assign at_end    = wr_idx_q == 6'(N_WORDS - 1);
  // Commit needs a full shadow, which holds s_ready low, so commit and a
  // last-word write can never land on the same edge.
  assign commit    = (state_q == IDLE) & shadow_full_q & (node_ready == 4'h0);
  always_comb begin
    wr_idx_d      = (wr_en & ~(at_end | s_last)) ? wr_idx_q + 6'd1 : wr_en ? 6'd0 : wr_idx_q;
    shadow_full_d = commit ? 1'b0 : (wr_en & at_end & s_last) ? 1'b1 : shadow_full_q;
    // Malformed: s_last early, or the 40th word without s_last.
    frame_err_d   = wr_en & (at_end ^ s_last);
  end
  // Shadow contents are don't-care after reset or a dropped frame.
  always_ff @(posedge clk)
    if (wr_en) shadow_q[wr_idx_q] <= s_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_idx_q      <= '0;
      shadow_full_q <= 1'b0;
      frame_err_q   <= 1'b0;
      feat_q        <= '0;
      wgt_q         <= '0;
      in_ready_q    <= 1'b0;
      frame_cnt_q   <= '0;
`ifdef GNN_LOADER_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      wr_idx_q      <= wr_idx_d;
      shadow_full_q <= shadow_full_d;
      frame_err_q   <= frame_err_d;
`ifdef GNN_LOADER_TIMEOUT_EN
      timeout_q     <= 1'b0;
`endif
      case (state_q)
        IDLE:
          if (commit) begin
            for (int i = 0; i < N_FEAT; i++) feat_q[i*DATA_W +: DATA_W] <= shadow_q[i];
            for (int i = 0; i < N_WGT; i++) wgt_q[i*DATA_W +: DATA_W] <= shadow_q[N_FEAT+i];
            in_ready_q <= 1'b1;
            state_q    <= RUN;
`ifdef GNN_LOADER_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
          end
        RUN:
          if (node_ready == 4'hF) begin
            in_ready_q  <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 8'd1;
            state_q     <= RELEASE;
          end
`ifdef GNN_LOADER_TIMEOUT_EN
          else if (tmo_cnt_q == 16'(TIMEOUT_CYC - 1)) begin
            timeout_q  <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= RELEASE;
          end else tmo_cnt_q <= tmo_cnt_q + 16'd1;
`endif
        // The array's clock keeps running while its flags are high, so they clear.
        RELEASE:
          if (node_ready == 4'h0) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_gnn_frame_loader.sv
// tb_gnn_frame_loader: table-driven bench for gnn_frame_loader.
module tb_gnn_frame_loader;
  localparam int TMO = 64;
  typedef struct packed {
    logic       v;
    logic [4:0] d;
    logic       l;
    logic [3:0] nr;
    logic       ei;
    logic       es;
    logic       ee;
    logic [7:0] ec;
  } vec_t;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic [4:0]   s_data = '0;
  logic [3:0]   node_ready = '0;
  logic         s_ready, in_ready, frame_err, timeout;
  logic [79:0]  feat;
  logic [119:0] wgt;
  logic [7:0]   frame_cnt;
  int           checks = 0;
  int           errors = 0;
  vec_t         tbl[$];
  int           m1, m2, m3, m4, m5;
  logic [199:0] pa, pb, pc;
  always #5 clk = ~clk;
  gnn_frame_loader #(.DATA_W(5), .N_WORDS(40), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .node_ready(node_ready), .feat(feat), .wgt(wgt), .in_ready(in_ready),
    .frame_err(frame_err), .timeout(timeout), .frame_cnt(frame_cnt)
  );
  function automatic logic [199:0] pat(int mul, int base);
    logic [199:0] p = '0;
    for (int w = 0; w < 40; w++) p[w*5 +: 5] = 5'(w * mul + base);
    return p;
  endfunction
  task automatic chk(string n, logic [119:0] a, logic [119:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask
  task automatic add(logic v, logic [4:0] d, logic l, logic [3:0] nr, logic ei, logic es,
                     logic ee, logic [7:0] ec);
    tbl.push_back('{v, d, l, nr, ei, es, ee, ec});
  endtask
  task automatic load(int n, int mul, int base, bit last, logic ei, logic [7:0] ec);
    for (int w = 0; w < n; w++) begin
      bit fin = (w == n - 1);
      bit l = fin & last;
      add(1'b1, 5'(w * mul + base), l, 4'h0, ei, !(l && n == 40),
          fin && ((l && n < 40) || (n == 40 && !l)), ec);
    end
  endtask
  task automatic cyc(logic v, logic [4:0] d, logic l, logic [3:0] nr);
    s_valid = v; s_data = d; s_last = l; node_ready = nr;
    @(posedge clk); #1;
  endtask
  task automatic run(int lo, int hi);
    for (int i = lo; i < hi; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].nr);
      chk($sformatf("in_ready[%0d]", i), 120'(in_ready), 120'(tbl[i].ei));
      chk($sformatf("s_ready[%0d]", i), 120'(s_ready), 120'(tbl[i].es));
      chk($sformatf("frame_err[%0d]", i), 120'(frame_err), 120'(tbl[i].ee));
      chk($sformatf("frame_cnt[%0d]", i), 120'(frame_cnt), 120'(tbl[i].ec));
    end
  endtask
  initial begin
    pa = pat(1, 1);
    pb = pat(3, 3);
    pc = pat(1, 10);
    load(40, 1, 1, 1, 0, 0);
    add(0, 0, 0, 4'h0, 1, 1, 0, 0);
    m1 = tbl.size();
    repeat (5) add(0, 0, 0, 4'h7, 1, 1, 0, 0);
    add(0, 0, 0, 4'hF, 0, 1, 0, 1);
    add(0, 0, 0, 4'hF, 0, 1, 0, 1);
    add(0, 0, 0, 4'h0, 0, 1, 0, 1);
    load(12, 1, 1, 1, 0, 1);
    add(0, 0, 0, 4'h0, 0, 1, 0, 1);
    load(40, 3, 3, 1, 0, 1);
    add(0, 0, 0, 4'h0, 1, 1, 0, 1);
    m2 = tbl.size();
    load(40, 1, 10, 1, 1, 1);
    add(0, 0, 0, 4'h0, 1, 0, 0, 1);
    m3 = tbl.size();
    add(0, 0, 0, 4'hF, 0, 0, 0, 2);
    add(0, 0, 0, 4'hF, 0, 0, 0, 2);
    add(0, 0, 0, 4'h0, 0, 0, 0, 2);
    m4 = tbl.size();
    add(0, 0, 0, 4'h0, 1, 1, 0, 2);
    m5 = tbl.size();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 120'(in_ready), 120'(0));
    chk("rst_s_ready", 120'(s_ready), 120'(1));
    chk("rst_feat", 120'(feat), 120'(0));
    chk("rst_wgt", wgt, 120'(0));
    chk("rst_cnt", 120'(frame_cnt), 120'(0));
    chk("rst_timeout", 120'(timeout), 120'(0));
    rst_n = 1'b1;
    run(0, m1);
    chk("f1_feat0", 120'(feat[4:0]), 120'(1));
    chk("f1_feat1", 120'(feat[9:5]), 120'(2));
    chk("f1_wgt23", 120'(wgt[119:115]), 120'(8));
    chk("f1_feat", 120'(feat), 120'(pa[79:0]));
    chk("f1_wgt", wgt, pa[199:80]);
    run(m1, m2);
    chk("clean_feat", 120'(feat), 120'(pb[79:0]));
    chk("clean_wgt", wgt, pb[199:80]);
    chk("clean_wgt23", 120'(wgt[119:115]), 120'(24));
    run(m2, m3);
    chk("a_feat_held_load", 120'(feat), 120'(pb[79:0]));
    run(m3, m4);
    chk("a_feat_held_rel", 120'(feat), 120'(pb[79:0]));
    chk("a_wgt_held_rel", wgt, pb[199:80]);
    run(m4, m5);
    chk("b_feat", 120'(feat), 120'(pc[79:0]));
    chk("b_wgt", wgt, pc[199:80]);
    chk("b_feat0", 120'(feat[4:0]), 120'(10));
    for (int w = 0; w < 20; w++) cyc(1, 5'(w), 0, 4'h0);
    rst_n = 1'b0;
    #1;
    chk("rst20_in_ready", 120'(in_ready), 120'(0));
    chk("rst20_feat", 120'(feat), 120'(0));
    chk("rst20_cnt", 120'(frame_cnt), 120'(0));
    chk("rst20_s_ready", 120'(s_ready), 120'(1));
    cyc(0, 0, 0, 4'h0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 4'h0);
    chk("rst20_s_ready_rel", 120'(s_ready), 120'(1));
    for (int w = 0; w < 40; w++) cyc(1, 5'(w + 5), 1'(w == 39), 4'h0);
    cyc(0, 0, 0, 4'h0);
    chk("d_in_ready", 120'(in_ready), 120'(1));
    chk("d_feat", 120'(feat), 120'(pat(1, 5) & 200'({80{1'b1}})));
    cyc(0, 0, 0, 4'h7);
    cyc(0, 0, 0, 4'h7);
    chk("d_run_hold", 120'(in_ready), 120'(1));
    rst_n = 1'b0;
    #1;
    chk("rstrun_in_ready", 120'(in_ready), 120'(0));
    chk("rstrun_feat", 120'(feat), 120'(0));
    chk("rstrun_wgt", wgt, 120'(0));
    cyc(0, 0, 0, 4'h0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 4'h0);
    chk("rstrun_s_ready", 120'(s_ready), 120'(1));
    for (int w = 0; w < 40; w++) cyc(1, 5'(w), 1'(w == 39), 4'h0);
    cyc(0, 0, 0, 4'h0);
    chk("t_in_ready", 120'(in_ready), 120'(1));
    repeat (TMO - 1) cyc(0, 0, 0, 4'h0);
    chk("t_pre_in_ready", 120'(in_ready), 120'(1));
    chk("t_pre_timeout", 120'(timeout), 120'(0));
    cyc(0, 0, 0, 4'h0);
`ifdef GNN_LOADER_TIMEOUT_EN
    chk("t_fire_timeout", 120'(timeout), 120'(1));
    chk("t_fire_in_ready", 120'(in_ready), 120'(0));
    chk("t_fire_cnt", 120'(frame_cnt), 120'(0));
    cyc(0, 0, 0, 4'h0);
    chk("t_pulse_end", 120'(timeout), 120'(0));
`else
    chk("t_none_timeout", 120'(timeout), 120'(0));
    chk("t_none_in_ready", 120'(in_ready), 120'(1));
    cyc(0, 0, 0, 4'hF);
    chk("t_none_cnt", 120'(frame_cnt), 120'(1));
    chk("t_none_drop", 120'(in_ready), 120'(0));
`endif
    cyc(0, 0, 0, 4'h0);
    for (int w = 0; w < 40; w++) cyc(1, 5'(w), 0, 4'h0);
    chk("nolast_err", 120'(frame_err), 120'(1));
    chk("nolast_s_ready", 120'(s_ready), 120'(1));
    cyc(0, 0, 0, 4'h0);
    chk("nolast_err_end", 120'(frame_err), 120'(0));
    chk("nolast_in_ready", 120'(in_ready), 120'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
